// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC sequencer: PC width, default vectors and FSM state encodings.
// The trap vector default is only consumed when pc_sequencer is built with PC_TRAP_EN.
package pc_pkg;

   localparam int PC_W = 16;

   localparam logic [PC_W-1:0] DEF_RESET_VEC = 16'h0000;
   localparam logic [PC_W-1:0] DEF_TRAP_VEC  = 16'h0010;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_FLUSH = 2'b10,
      ST_HALT  = 2'b11
   } pcState_t;

endpackage

// File: rtl/pc_flush_ctr.sv
// Loadable 3-bit down-counter that times the IF/ID flush window after a redirect.
// A load wins over hold; the count stops at zero and the zero flag reports it.
module pc_flush_ctr (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       hold,
   input  logic [2:0] loadValue,
   output logic [2:0] count,
   output logic       zero
);

   // Count register: cleared asynchronously so flush drops the moment reset is seen.
   // A hazard stall holds the count so the flush window stretches with the frozen pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 3'd0;
      end else if (load) begin
         count <= loadValue;
      end else if (!hold && (count != 3'd0)) begin
         count <= count - 3'd1;
      end
   end

   assign zero = (count == 3'd0);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: boot vector, sequential fetch, branch, stall and halt.
// Define PC_TRAP_EN to add the trap_req port and the TRAP_VEC redirect path.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VEC    = DEF_RESET_VEC,
`ifdef PC_TRAP_EN
   parameter logic [PC_W-1:0] TRAP_VEC     = DEF_TRAP_VEC,
`endif
   parameter int              INC          = 2,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            halt,
   input  logic            resume,
`ifdef PC_TRAP_EN
   input  logic            trap_req,
`endif
   input  logic [PC_W-1:0] pc_cur,
   output logic [PC_W-1:0] pc_next,
   output logic            pc_wr_en,
   output logic            flush,
   output logic [1:0]      state
);

   localparam logic [PC_W-1:0] INC_VAL   = PC_W'(INC);
   localparam logic [2:0]      FLUSH_VAL = 3'(FLUSH_CYCLES);

   pcState_t        curState;
   pcState_t        nextState;
   logic [PC_W-1:0] seqPc;
   logic [PC_W-1:0] branchPc;
   logic            ctrLoad;
   logic            ctrHold;
   logic [2:0]      ctrCount;
   logic            ctrZero;

   // Sequential fetch wraps modulo 2^16; with 2-byte fetch the target is kept halfword aligned.
   assign seqPc = pc_cur + INC_VAL;

   always_comb begin
      branchPc = br_target;
      if (INC == 2) begin
         branchPc[0] = 1'b0;
      end
   end

   // State register: reset always lands in BOOT so the boot vector is written on release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curState <= ST_BOOT;
      end else begin
         curState <= nextState;
      end
   end

   // Next-state and PC source selection. Redirects take effect in the same cycle they are
   // requested; the priority chain is trap, branch, halt, stall, then sequential fetch.
   // FLUSH leaves for RUN on the cycle the counter is about to reach zero, so the FLUSH
   // state and the flush output stay aligned.
   always_comb begin
      nextState = curState;
      pc_next   = pc_cur;
      pc_wr_en  = 1'b0;
      ctrLoad   = 1'b0;
      ctrHold   = 1'b0;
      case (curState)
         ST_BOOT: begin
            pc_next   = RESET_VEC;
            pc_wr_en  = ~rst;
            nextState = ST_RUN;
         end
         ST_RUN, ST_FLUSH: begin
`ifdef PC_TRAP_EN
            if (trap_req) begin
               pc_next   = TRAP_VEC;
               pc_wr_en  = 1'b1;
               ctrLoad   = 1'b1;
               nextState = ST_FLUSH;
            end else
`endif
            if (br_taken) begin
               pc_next   = branchPc;
               pc_wr_en  = 1'b1;
               ctrLoad   = 1'b1;
               nextState = ST_FLUSH;
            end else if (halt) begin
               nextState = ST_HALT;
            end else if (stall) begin
               ctrHold = 1'b1;
            end else begin
               pc_next  = seqPc;
               pc_wr_en = 1'b1;
               if ((curState == ST_FLUSH) && (ctrCount <= 3'd1)) begin
                  nextState = ST_RUN;
               end
            end
         end
         ST_HALT: begin
`ifdef PC_TRAP_EN
            if (trap_req) begin
               pc_next   = TRAP_VEC;
               pc_wr_en  = 1'b1;
               ctrLoad   = 1'b1;
               nextState = ST_FLUSH;
            end else
`endif
            if (resume) begin
               pc_next   = seqPc;
               pc_wr_en  = 1'b1;
               nextState = ST_RUN;
            end
         end
         default: begin
            nextState = ST_BOOT;
         end
      endcase
   end

   pc_flush_ctr u_flush_ctr (
      .clk       (clk),
      .rst       (rst),
      .load      (ctrLoad),
      .hold      (ctrHold),
      .loadValue (FLUSH_VAL),
      .count     (ctrCount),
      .zero      (ctrZero)
   );

   assign flush = ~ctrZero;
   assign state = curState;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters (INC=2, FLUSH_CYCLES=2).
// Trap scenarios are exercised only when PC_TRAP_EN is defined for the build.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        br_taken;
   logic [15:0] br_target;
   logic        halt;
   logic        resume;
   logic        trap_req;
   logic [15:0] pc_cur;
   logic [15:0] pc_next;
   logic        pc_wr_en;
   logic        flush;
   logic [1:0]  state;

   int compared;
   int mismatched;

   localparam logic [1:0] BOOT  = 2'b00;
   localparam logic [1:0] RUN   = 2'b01;
   localparam logic [1:0] FLUSH = 2'b10;
   localparam logic [1:0] HALT  = 2'b11;

   pc_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .br_taken  (br_taken),
      .br_target (br_target),
      .halt      (halt),
      .resume    (resume),
`ifdef PC_TRAP_EN
      .trap_req  (trap_req),
`endif
      .pc_cur    (pc_cur),
      .pc_next   (pc_next),
      .pc_wr_en  (pc_wr_en),
      .flush     (flush),
      .state     (state)
   );

   // Free-running clock, rising edge active.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs on the falling edge and settles 1 ns, well before the next rising edge.
   task automatic applyStimulus(input logic [15:0] pc, input logic st, input logic br,
                                input logic [15:0] tgt, input logic hl, input logic rs,
                                input logic tr);
      @(negedge clk);
      pc_cur    = pc;
      stall     = st;
      br_taken  = br;
      br_target = tgt;
      halt      = hl;
      resume    = rs;
      trap_req  = tr;
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(16'h0000, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (state !== BOOT) begin mismatched++; $display("[TB] FAIL reset_state: got %b expected %b", state, BOOT); end
      compared++; if (pc_wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr_en: got %b expected 0", pc_wr_en); end
      compared++; if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flush: got %b expected 0", flush); end
      compared++; if (pc_next !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_pc_next: got %h expected 0000", pc_next); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      compared++; if (pc_wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL boot_wr_en: got %b expected 1", pc_wr_en); end
      compared++; if (pc_next !== 16'h0000) begin mismatched++; $display("[TB] FAIL boot_pc_next: got %h expected 0000", pc_next); end
      applyStimulus(16'h0000, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (state !== RUN) begin mismatched++; $display("[TB] FAIL boot_to_run: got %b expected %b", state, RUN); end
      compared++; if (pc_next !== 16'h0002) begin mismatched++; $display("[TB] FAIL first_seq: got %h expected 0002", pc_next); end
   endtask

   task automatic test_branch();
      applyStimulus(16'h1100, 0, 1, 16'h16A1, 0, 0, 0);
      compared++; if (pc_next !== 16'h16A0) begin mismatched++; $display("[TB] FAIL br_pc_next: got %h expected 16a0", pc_next); end
      compared++; if (pc_wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL br_wr_en: got %b expected 1", pc_wr_en); end
      compared++; if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL br_flush_early: got %b expected 0", flush); end
      applyStimulus(16'h16A0, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL br_flush_1: got %b expected 1", flush); end
      compared++; if (state !== FLUSH) begin mismatched++; $display("[TB] FAIL br_state_1: got %b expected %b", state, FLUSH); end
      compared++; if (pc_next !== 16'h16A2) begin mismatched++; $display("[TB] FAIL br_seq_in_flush: got %h expected 16a2", pc_next); end
      applyStimulus(16'h16A2, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL br_flush_2: got %b expected 1", flush); end
      compared++; if (state !== FLUSH) begin mismatched++; $display("[TB] FAIL br_state_2: got %b expected %b", state, FLUSH); end
      applyStimulus(16'h16A4, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL br_flush_end: got %b expected 0", flush); end
      compared++; if (state !== RUN) begin mismatched++; $display("[TB] FAIL br_state_end: got %b expected %b", state, RUN); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(16'h1206, 1, 0, 16'h0000, 0, 0, 0);
         compared++; if (pc_wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_wr_en[%0d]: got %b expected 0", i, pc_wr_en); end
         compared++; if (pc_next !== 16'h1206) begin mismatched++; $display("[TB] FAIL stall_pc_next[%0d]: got %h expected 1206", i, pc_next); end
      end
      applyStimulus(16'h1206, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (pc_next !== 16'h1208) begin mismatched++; $display("[TB] FAIL stall_release: got %h expected 1208", pc_next); end
      compared++; if (pc_wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_release_wr: got %b expected 1", pc_wr_en); end
   endtask

   // Branch beats stall; stalls inside FLUSH then stretch the flush window to four cycles.
   task automatic test_stall_vs_branch();
      applyStimulus(16'h2000, 1, 1, 16'h7020, 0, 0, 0);
      compared++; if (pc_next !== 16'h7020) begin mismatched++; $display("[TB] FAIL sb_pc_next: got %h expected 7020", pc_next); end
      compared++; if (pc_wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL sb_wr_en: got %b expected 1", pc_wr_en); end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(16'h7020, 1, 0, 16'h0000, 0, 0, 0);
         compared++; if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL sb_hold_flush[%0d]: got %b expected 1", i, flush); end
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(16'h7020, 0, 0, 16'h0000, 0, 0, 0);
         compared++; if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL sb_drain_flush[%0d]: got %b expected 1", i, flush); end
      end
      applyStimulus(16'h7024, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL sb_flush_end: got %b expected 0", flush); end
      compared++; if (state !== RUN) begin mismatched++; $display("[TB] FAIL sb_state_end: got %b expected %b", state, RUN); end
   endtask

   // A second branch inside FLUSH reloads the counter.
   task automatic test_back_to_back();
      applyStimulus(16'h3000, 0, 1, 16'h4000, 0, 0, 0);
      applyStimulus(16'h4000, 0, 1, 16'h5001, 0, 0, 0);
      compared++; if (pc_next !== 16'h5000) begin mismatched++; $display("[TB] FAIL b2b_pc_next: got %h expected 5000", pc_next); end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(16'h5000, 0, 0, 16'h0000, 0, 0, 0);
         compared++; if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_flush[%0d]: got %b expected 1", i, flush); end
      end
      applyStimulus(16'h5004, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_flush_end: got %b expected 0", flush); end
   endtask

   task automatic test_wrap();
      applyStimulus(16'hFFFE, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (pc_next !== 16'h0000) begin mismatched++; $display("[TB] FAIL wrap_pc_next: got %h expected 0000", pc_next); end
      applyStimulus(16'h0000, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_flush: got %b expected 0", flush); end
      compared++; if (state !== RUN) begin mismatched++; $display("[TB] FAIL wrap_state: got %b expected %b", state, RUN); end
   endtask

   task automatic test_halt();
      applyStimulus(16'h9999, 0, 0, 16'h0000, 1, 0, 0);
      compared++; if (pc_wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_wr_en: got %b expected 0", pc_wr_en); end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h9999, (i == 1), (i == 2), 16'h1234, 0, 0, 0);
         compared++; if (pc_wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_hold_wr[%0d]: got %b expected 0", i, pc_wr_en); end
         compared++; if (state !== HALT) begin mismatched++; $display("[TB] FAIL halt_state[%0d]: got %b expected %b", i, state, HALT); end
      end
      applyStimulus(16'h9999, 0, 0, 16'h0000, 0, 1, 0);
      compared++; if (pc_next !== 16'h999B) begin mismatched++; $display("[TB] FAIL resume_pc_next: got %h expected 999b", pc_next); end
      compared++; if (pc_wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL resume_wr_en: got %b expected 1", pc_wr_en); end
      applyStimulus(16'h999B, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (state !== RUN) begin mismatched++; $display("[TB] FAIL resume_state: got %b expected %b", state, RUN); end
   endtask

`ifdef PC_TRAP_EN
   task automatic test_trap();
      applyStimulus(16'h0100, 0, 1, 16'h2222, 1, 0, 1);
      compared++; if (pc_next !== 16'h0010) begin mismatched++; $display("[TB] FAIL trap_prio_pc: got %h expected 0010", pc_next); end
      applyStimulus(16'h0010, 0, 0, 16'h0000, 0, 0, 0);
      applyStimulus(16'h0012, 0, 0, 16'h0000, 0, 0, 0);
      applyStimulus(16'h0014, 0, 0, 16'h0000, 1, 0, 0);
      applyStimulus(16'h0014, 0, 0, 16'h0000, 0, 0, 1);
      compared++; if (state !== HALT) begin mismatched++; $display("[TB] FAIL trap_pre_state: got %b expected %b", state, HALT); end
      compared++; if (pc_next !== 16'h0010) begin mismatched++; $display("[TB] FAIL trap_halt_pc: got %h expected 0010", pc_next); end
      compared++; if (pc_wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL trap_halt_wr: got %b expected 1", pc_wr_en); end
      applyStimulus(16'h0010, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL trap_flush: got %b expected 1", flush); end
      compared++; if (state !== FLUSH) begin mismatched++; $display("[TB] FAIL trap_state: got %b expected %b", state, FLUSH); end
   endtask
`endif

   // Reset arriving mid-FLUSH must clear flush without waiting for a clock edge.
   task automatic test_reset_mid_flush();
      applyStimulus(16'h0200, 0, 1, 16'h0300, 0, 0, 0);
      applyStimulus(16'h0300, 0, 0, 16'h0000, 0, 0, 0);
      compared++; if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL rmf_flush_before: got %b expected 1", flush); end
      #1;
      rst = 1'b1;
      #1;
      compared++; if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL rmf_flush_async: got %b expected 0", flush); end
      compared++; if (state !== BOOT) begin mismatched++; $display("[TB] FAIL rmf_state: got %b expected %b", state, BOOT); end
      compared++; if (pc_wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL rmf_wr_en: got %b expected 0", pc_wr_en); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      compared++; if (pc_wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL rmf_boot_wr: got %b expected 1", pc_wr_en); end
      compared++; if (pc_next !== 16'h0000) begin mismatched++; $display("[TB] FAIL rmf_boot_pc: got %h expected 0000", pc_next); end
   endtask

   // Runs every scenario in order and prints the tally.
   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      stall      = 1'b0;
      br_taken   = 1'b0;
      br_target  = 16'h0000;
      halt       = 1'b0;
      resume     = 1'b0;
      trap_req   = 1'b0;
      pc_cur     = 16'h0000;
      $display("[TB] starting pc_sequencer directed tests");
      test_reset();
      test_branch();
      test_stall();
      test_stall_vs_branch();
      test_back_to_back();
      test_wrap();
      test_halt();
`ifdef PC_TRAP_EN
      test_trap();
`endif
      test_reset_mid_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
